tone_wave_gen: RTL
==================

Name: tone_wave_gen

Overview:
- Downstream consumer of the tone selector's 32-bit clock-divider word `Clk_div_num`.
- Generates a 50%-duty square wave whose half-period is `Clk_div_num` cycles of `CLOCK_50`. Example: 0xBAA2 = 47778 gives ≈523 Hz.
- Also produces a signed audio sample, served to the audio codec interface through a request/valid handshake.
- Divider changes are applied only at half-period boundaries, so switching notes never produces a runt pulse.

Parameters:
- SAMPLE_W, 24, width of the signed audio sample.
- AMPLITUDE, 24'sh200000, positive sample magnitude. The negative level is -AMPLITUDE.
- MIN_DIV, 2, smallest half-period accepted. Smaller divider values are clamped up to MIN_DIV.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- Clk_div_num  input  32  requested half-period in clock cycles, from the tone selector.
- enable  input  1  tone on/off. 0 = silence.
- tone_out  output  1  square wave.
- toggle_pulse  output  1  one-cycle pulse on each `tone_out` transition.
- sample_req  input  1  codec requests the next sample (single-cycle or held).
- sample_valid  output  1  one-cycle pulse; `sample_data` is valid in that cycle.
- sample_data  output  SAMPLE_W  signed sample, two's complement.
- div_active  output  32  half-period currently in use (for debug/verification).

Behaviour:
- Reset (synchronous, priority over everything):
  - cnt = 0, phase = 0.
  - div_active = MIN_DIV.
  - tone_out = 0, toggle_pulse = 0, sample_valid = 0, sample_data = 0.
- Divider clamp: eff_div = (Clk_div_num < MIN_DIV) ? MIN_DIV : Clk_div_num. All comparisons are unsigned 32-bit.
- Disabled state (enable = 0):
  - cnt and phase are held at 0; tone_out = 0; toggle_pulse = 0.
  - div_active <= eff_div every cycle, so a new note is adopted immediately while silent.
- Running state (enable = 1):
  - Each cycle: if cnt == div_active - 1 (terminal count), then:
    - cnt <= 0;
    - phase <= ~phase; tone_out follows phase (registered);
    - toggle_pulse <= 1;
    - div_active <= eff_div.
  - Otherwise cnt <= cnt + 1, toggle_pulse <= 0, and div_active is held.
  - Each half-period is therefore exactly div_active cycles long. Full period = 2 × div_active.
- Divider change mid-half-period: the current half-period completes with the old value. The new value applies starting with the next half-period. Multiple changes within one half-period: only the value present at the terminal cycle is taken.
- enable 0→1: counting starts that cycle from cnt = 0 with phase = 0. The first toggle (tone_out → 1) happens at the div_active-th rising edge after enable is sampled high.
- enable 1→0 mid-period: the next cycle returns to the disabled state (tone_out = 0, counters cleared). No completion of the current half-period.
- Sample path:
  - The sample is derived from phase and enable in the same cycle that sample_req is sampled high.
  - The cycle after sample_req is sampled high: sample_valid = 1 and sample_data = enable ? (phase ? +AMPLITUDE : -AMPLITUDE) : 0.
  - sample_valid is high for exactly one cycle per request cycle. A held sample_req yields a valid pulse every cycle (throughput 1/cycle).
  - sample_data holds its last value when sample_valid = 0.
- Simultaneous events:
  - sample_req in the same cycle as a terminal-count toggle returns the pre-toggle phase value.
  - reset and sample_req together: reset wins; no sample_valid follows.
- Counter never exceeds div_active - 1.
- An upstream divider of 0xFFFFFFFF is legal. The count wraps only via terminal-count reload, never via 32-bit overflow.

Test Plan:
- Reset then enable = 1, Clk_div_num = 4 → tone_out pattern 0000 1111 0000 1111…; toggle_pulse at cycles 4, 8, 12 after enable; div_active = 4.
- Clk_div_num = 0 and 1 with enable = 1 → div_active = 2; tone_out period = 4 cycles.
- Running at div 6, change to 3 at cycle 2 of a half-period → that half-period is 6 cycles, subsequent half-periods are 3 cycles, no shorter pulse.
- enable dropped mid-half-period at div 10 → tone_out = 0 next cycle. Re-enable → first rise exactly 10 cycles later.
- sample_req held for 5 cycles with div 2, AMPLITUDE default → sample_valid high 5 consecutive cycles; sample_data alternates between 0x200000 and 0xE00000 with a one-cycle lag from phase. With enable = 0 → sample_data = 0.
- Assert reset during running at div 0xBAA2 with sample_req high → next cycle all outputs are at reset values and sample_valid = 0. Afterwards, at div 0xBAA2, the measured half-period is 47778 cycles.

Source files
------------

// File: rtl/tone_wave_gen.sv
`default_nettype none
// =============================================================================
// Module   : tone_wave_gen
// Brief    : 50%-duty square-wave tone generator with a request/valid signed
//            audio sample port for the codec interface.
// Revision : 1.0 - initial release
// =============================================================================
module tone_wave_gen #(
    parameter int                          SAMPLE_W  = 24,
    parameter logic signed [SAMPLE_W-1:0]  AMPLITUDE = 24'sh200000,
    parameter int unsigned                 MIN_DIV   = 2
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic [31:0]                Clk_div_num,
    input  logic                       enable,
    output logic                       tone_out,
    output logic                       toggle_pulse,
    input  logic                       sample_req,
    output logic                       sample_valid,
    output logic signed [SAMPLE_W-1:0] sample_data,
    output logic [31:0]                div_active
);

    localparam logic [31:0] c_min_div = 32'(MIN_DIV);

    logic [31:0]                r_cnt;
    logic                       r_phase;
    logic [31:0]                r_div_active;
    logic                       r_toggle;
    logic                       r_sample_valid;
    logic signed [SAMPLE_W-1:0] r_sample_data;

    logic [31:0]                w_eff_div;
    logic                       w_terminal;
    logic signed [SAMPLE_W-1:0] w_sample;

    assign w_eff_div  = (Clk_div_num < c_min_div) ? c_min_div : Clk_div_num;
    // div_active never drops below MIN_DIV, so the subtraction cannot wrap
    assign w_terminal = (r_cnt == (r_div_active - 32'd1));
    assign w_sample   = !enable ? '0 : (r_phase ? AMPLITUDE : -AMPLITUDE);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_cnt        <= '0;
            r_phase      <= 1'b0;
            r_div_active <= c_min_div;
            r_toggle     <= 1'b0;
        end else if (!enable) begin
            r_cnt        <= '0;
            r_phase      <= 1'b0;
            r_div_active <= w_eff_div;
            r_toggle     <= 1'b0;
        end else if (w_terminal) begin
            // New divider is only adopted here, so a half-period is never cut short
            r_cnt        <= '0;
            r_phase      <= ~r_phase;
            r_div_active <= w_eff_div;
            r_toggle     <= 1'b1;
        end else begin
            r_cnt        <= r_cnt + 32'd1;
            r_toggle     <= 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_sample_valid <= 1'b0;
            r_sample_data  <= '0;
        end else if (sample_req) begin
            r_sample_valid <= 1'b1;
            r_sample_data  <= w_sample;
        end else begin
            r_sample_valid <= 1'b0;
        end
    end

    assign tone_out     = r_phase;
    assign toggle_pulse = r_toggle;
    assign div_active   = r_div_active;
    assign sample_valid = r_sample_valid;
    assign sample_data  = r_sample_data;

endmodule
`default_nettype wire
